pixel_adc_ctrl: RTL and testbench

// Companion to the pixel state FSM: generates expose_finished and ADC_finished.

---
 rtl/pixel_pkg.sv | 26 ++
 rtl/pixel_adc_ctrl_if.sv | 28 ++
 rtl/pixel_expose_timer.sv | 67 ++++++
 rtl/pixel_adc_ctrl.sv | 147 ++++++++++++++
 tb/tb_pixel_adc_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared types and default sizing for the pixel ADC controller.
package pixel_pkg;

  localparam int N_PIX_DEF    = 4;
  localparam int ADC_BITS_DEF = 8;
  localparam int EXP_BITS_DEF = 6;

  typedef enum logic [1:0] {
    EXP_IDLE,
    EXP_RUN,
    EXP_DONE
  } exp_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_RESET,
    A_RAMP,
    A_DONE
  } adc_state_t;

  // Index width that stays legal for a single-pixel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_adc_ctrl_if.sv
// Readout stream: one code per pixel over valid/ready, plus the overrun flag.
interface pixel_adc_ctrl_if
  import pixel_pkg::*;
#(
  parameter int N_PIX    = N_PIX_DEF,
  parameter int ADC_BITS = ADC_BITS_DEF
) ();

  localparam int IDX_W = idx_width(N_PIX);

  logic                rd_valid;
  logic                rd_ready;
  logic [IDX_W-1:0]    rd_idx;
  logic [ADC_BITS-1:0] rd_data;
  logic                rd_last;
  logic                rd_overrun;

  modport master (
    output rd_valid, rd_idx, rd_data, rd_last, rd_overrun,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_idx, rd_data, rd_last, rd_overrun,
    output rd_ready
  );

endinterface

// File: rtl/pixel_expose_timer.sv
// Exposure window timer: counts expose_cycles after a rising expose_enable.
//
// state    | meaning
// EXP_IDLE | waiting for expose_enable rising edge
// EXP_RUN  | counting the exposure window
// EXP_DONE | exposure complete, held until expose_enable drops
module pixel_expose_timer
  import pixel_pkg::*;
#(
  parameter int EXP_BITS = EXP_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                expose_enable,
  input  logic [EXP_BITS-1:0] expose_cycles,
  output logic                expose_finished
);

  localparam logic [EXP_BITS-1:0] ONE = EXP_BITS'(1);

  exp_state_t          state, state_nxt;
  logic [EXP_BITS-1:0] cnt;
  logic [EXP_BITS-1:0] len;
  logic                en_q;
  logic                rise;

  assign rise            = expose_enable & ~en_q;
  assign expose_finished = (state == EXP_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= EXP_IDLE;
    else       state <= state_nxt;
  end

  // Next state; a zero length finishes straight from the rising edge.
  always_comb begin
    state_nxt = state;
    case (state)
      EXP_IDLE: if (rise) state_nxt = (expose_cycles == '0) ? EXP_DONE : EXP_RUN;
      EXP_RUN: begin
        if (!expose_enable)        state_nxt = EXP_IDLE;
        else if (cnt == len - ONE) state_nxt = EXP_DONE;
      end
      EXP_DONE: if (!expose_enable) state_nxt = EXP_IDLE;
      default:  state_nxt = EXP_IDLE;
    endcase
  end

  // Edge detector, captured length and running count.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= 1'b0;
      cnt  <= '0;
      len  <= '0;
    end else begin
      en_q <= expose_enable;
      if (state == EXP_IDLE && rise) begin
        cnt <= '0;
        len <= expose_cycles;
      end else if (state == EXP_RUN) begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/pixel_adc_ctrl.sv
// Exposure timing plus single-slope ramp ADC with per-pixel code latches and streamed readout.
//
// state   | meaning
// A_IDLE  | idle, disarmed after reset or an aborted ramp
// A_RESET | codes cleared, armed, waiting for convert
// A_RAMP  | ramp running, latching codes as comparators fire
// A_DONE  | codes valid, ADC_finished high, readout streaming
module pixel_adc_ctrl
  import pixel_pkg::*;
#(
  parameter int N_PIX    = N_PIX_DEF,
  parameter int ADC_BITS = ADC_BITS_DEF,
  parameter int EXP_BITS = EXP_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                expose_enable,
  input  logic [EXP_BITS-1:0] expose_cycles,
  output logic                expose_finished,
  input  logic                ADC_reset,
  input  logic                convert,
  input  logic [N_PIX-1:0]    cmp,
  output logic [ADC_BITS-1:0] dac_code,
  output logic                ADC_finished,
  pixel_adc_ctrl_if.master    rd
);

  localparam int                  IDX_W    = idx_width(N_PIX);
  localparam logic [ADC_BITS-1:0] FULL     = '1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_PIX - 1);

  adc_state_t          adc_state, adc_nxt;
  logic                armed;
  logic                rd_pend;
  logic                rd_valid;
  logic                rd_overrun;
  logic [IDX_W-1:0]    rd_idx;
  logic [ADC_BITS-1:0] dac;
  logic [ADC_BITS-1:0] codes [N_PIX];
  logic [N_PIX-1:0]    lat;
  logic [N_PIX-1:0]    lat_nxt;
  logic                ramp_end;

  pixel_expose_timer #(.EXP_BITS(EXP_BITS)) u_expose (
    .clk             (clk),
    .reset           (reset),
    .expose_enable   (expose_enable),
    .expose_cycles   (expose_cycles),
    .expose_finished (expose_finished)
  );

  // The ramp stops once every pixel has latched or the full-scale step was compared.
  assign lat_nxt  = lat | cmp;
  assign ramp_end = (&lat_nxt) || (dac == FULL);

  assign dac_code      = dac;
  assign ADC_finished  = (adc_state == A_DONE);
  assign rd.rd_valid   = rd_valid;
  assign rd.rd_idx     = rd_idx;
  assign rd.rd_data    = codes[rd_idx];
  assign rd.rd_last    = rd_valid && (rd_idx == LAST_IDX);
  assign rd.rd_overrun = rd_overrun;

  // ADC state register.
  always_ff @(posedge clk) begin
    if (reset) adc_state <= A_IDLE;
    else       adc_state <= adc_nxt;
  end

  // ADC next state; ADC_reset wins over everything else.
  always_comb begin
    adc_nxt = adc_state;
    if (ADC_reset) begin
      adc_nxt = A_RESET;
    end else begin
      case (adc_state)
        A_IDLE, A_RESET: if (convert && armed) adc_nxt = A_RAMP;
        A_RAMP: begin
          if (!convert)     adc_nxt = A_IDLE;
          else if (ramp_end) adc_nxt = A_DONE;
        end
        default: adc_nxt = adc_state;
      endcase
    end
  end

  // Ramp counter, code latches, arming and readout sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b0;
      rd_pend    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_overrun <= 1'b0;
      rd_idx     <= '0;
      dac        <= '0;
      lat        <= '0;
      for (int i = 0; i < N_PIX; i++) codes[i] <= '0;
    end else begin
      rd_overrun <= 1'b0;
      if (ADC_reset) begin
        rd_overrun <= rd_valid;
        rd_valid   <= 1'b0;
        rd_pend    <= 1'b0;
        rd_idx     <= '0;
        armed      <= 1'b1;
        dac        <= '0;
        lat        <= '0;
        for (int i = 0; i < N_PIX; i++) codes[i] <= '0;
      end else begin
        case (adc_state)
          A_IDLE, A_RESET: if (convert && armed) dac <= '0;
          A_RAMP: begin
            if (!convert) begin
              armed <= 1'b0;
            end else begin
              lat <= lat_nxt;
              for (int i = 0; i < N_PIX; i++) begin
                if (cmp[i] && !lat[i]) codes[i] <= dac;
              end
              if (ramp_end) begin
                armed   <= 1'b0;
                rd_pend <= 1'b1;
                for (int i = 0; i < N_PIX; i++) begin
                  if (!lat_nxt[i]) codes[i] <= FULL;
                end
              end else begin
                dac <= dac + 1'b1;
              end
            end
          end
          A_DONE: begin
            if (rd_pend) begin
              rd_pend  <= 1'b0;
              rd_valid <= 1'b1;
              rd_idx   <= '0;
            end else if (rd_valid && rd.rd_ready) begin
              if (rd_idx == LAST_IDX) rd_valid <= 1'b0;
              else                    rd_idx   <= rd_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_adc_ctrl.sv
// Directed bench for pixel_adc_ctrl: comparator model driven from dac_code,
// expected pixel codes queued when thresholds are programmed and popped at readout.
module tb_pixel_adc_ctrl;
  import pixel_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       expose_enable;
  logic [5:0] expose_cycles;
  logic       expose_finished;
  logic       ADC_reset;
  logic       convert;
  logic [3:0] cmp;
  logic [7:0] dac_code;
  logic       ADC_finished;

  int         checks   = 0;
  int         failures = 0;
  int         thr [4];
  logic [3:0] fire_en;
  logic [7:0] exp_q [$];

  pixel_adc_ctrl_if #(.N_PIX(4), .ADC_BITS(8)) rd_if ();

  pixel_adc_ctrl #(.N_PIX(4), .ADC_BITS(8), .EXP_BITS(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .expose_enable   (expose_enable),
    .expose_cycles   (expose_cycles),
    .expose_finished (expose_finished),
    .ADC_reset       (ADC_reset),
    .convert         (convert),
    .cmp             (cmp),
    .dac_code        (dac_code),
    .ADC_finished    (ADC_finished),
    .rd              (rd_if)
  );

  always #5 clk = ~clk;

  // Comparator model: output high once the ramp reaches the pixel threshold.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < 4; i++) cmp[i] = fire_en[i] && (int'(dac_code) >= thr[i]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Program thresholds and queue the codes the ramp should produce for them.
  task automatic set_pix(input int t0, input int t1, input int t2, input int t3, input logic [3:0] en);
    thr[0] = t0; thr[1] = t1; thr[2] = t2; thr[3] = t3;
    fire_en = en;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && thr[i] < 255) exp_q.push_back(8'(thr[i]));
      else                       exp_q.push_back(8'd255);
    end
  endtask

  // Consume the whole readout with rd_ready high, checking every beat against the queue.
  task automatic drain(input string tag);
    int n;
    int k;
    logic [7:0] e;
    n = 0;
    while (!rd_if.rd_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(rd_if.rd_data), 32'(e));
      chk({tag, "_idx"},  32'(rd_if.rd_idx),  32'(k));
      chk({tag, "_last"}, 32'(rd_if.rd_last), 32'(k == 3));
      step();
      k++;
    end
    chk({tag, "_end"}, 32'(rd_if.rd_valid), 32'd0);
  endtask

  initial begin
    int fin_at;
    int n;
    logic wrapped;
    logic seen;
    logic [7:0] prev;
    logic [7:0] e;

    reset = 1'b1; expose_enable = 1'b0; expose_cycles = '0;
    ADC_reset = 1'b0; convert = 1'b0; rd_if.rd_ready = 1'b0;
    fire_en = '0;
    for (int i = 0; i < 4; i++) thr[i] = 0;
    repeat (3) step();
    chk("rst_expfin", 32'(expose_finished), 0);
    chk("rst_dac",    32'(dac_code), 0);
    chk("rst_adcfin", 32'(ADC_finished), 0);
    chk("rst_valid",  32'(rd_if.rd_valid), 0);
    chk("rst_ovr",    32'(rd_if.rd_overrun), 0);
    chk("rst_last",   32'(rd_if.rd_last), 0);
    reset = 1'b0;
    step();

    // Exposure of 10 cycles: finished appears exactly 10 edges after the sampled rise.
    expose_cycles = 6'd10;
    expose_enable = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      step();
      chk("exp10", 32'(expose_finished), 32'(j == 10));
    end
    step();
    chk("exp10_hold", 32'(expose_finished), 1);
    expose_enable = 1'b0;
    step();
    chk("exp10_drop", 32'(expose_finished), 0);

    // Zero length finishes on the rise edge.
    expose_cycles = 6'd0;
    expose_enable = 1'b1;
    step();
    chk("exp0", 32'(expose_finished), 1);
    expose_enable = 1'b0;
    step();
    chk("exp0_drop", 32'(expose_finished), 0);

    // Abort at count 5 of 10.
    expose_cycles = 6'd10;
    expose_enable = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen |= expose_finished;
    end
    expose_enable = 1'b0;
    repeat (20) begin
      step();
      seen |= expose_finished;
    end
    chk("exp_abort", 32'(seen), 0);

    // Conversion with codes 3,12,12,40.
    set_pix(3, 12, 12, 40, 4'b1111);
    rd_if.rd_ready = 1'b1;
    ADC_reset = 1'b1;
    step();
    ADC_reset = 1'b0;
    chk("arm_dac", 32'(dac_code), 0);
    chk("arm_fin", 32'(ADC_finished), 0);
    convert = 1'b1;
    step();
    for (int j = 1; j <= 41; j++) begin
      step();
      chk("conv_fin", 32'(ADC_finished), 32'(j == 41));
      if (j == 20) chk("conv_dac20", 32'(dac_code), 20);
    end
    chk("conv_dac_end", 32'(dac_code), 40);
    drain("rd1");

    // Pixel 3 never fires: full scale, ramp ends after comparing 255, no wrap.
    convert = 1'b0;
    set_pix(3, 12, 12, 0, 4'b0111);
    ADC_reset = 1'b1;
    step();
    ADC_reset = 1'b0;
    convert = 1'b1;
    step();
    fin_at = -1; n = 0; wrapped = 1'b0; prev = '0;
    while (fin_at < 0 && n < 300) begin
      step();
      n++;
      if (dac_code < prev) wrapped = 1'b1;
      prev = dac_code;
      if (ADC_finished) fin_at = n;
    end
    chk("fs_fin_at", 32'(fin_at), 256);
    chk("fs_nowrap", 32'(wrapped), 0);
    chk("fs_dac", 32'(dac_code), 255);
    drain("rd2");

    // Back-pressure at idx1, then ADC_reset during readout.
    convert = 1'b0;
    rd_if.rd_ready = 1'b0;
    set_pix(5, 6, 7, 8, 4'b1111);
    ADC_reset = 1'b1;
    step();
    ADC_reset = 1'b0;
    convert = 1'b1;
    n = 0;
    while (!rd_if.rd_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp_valid", 32'(rd_if.rd_valid), 1);
    e = exp_q.pop_front();
    chk("bp_d0", 32'(rd_if.rd_data), 32'(e));
    rd_if.rd_ready = 1'b1;
    step();
    rd_if.rd_ready = 1'b0;
    e = exp_q.pop_front();
    repeat (5) begin
      step();
      chk("bp_hold_idx",  32'(rd_if.rd_idx), 1);
      chk("bp_hold_data", 32'(rd_if.rd_data), 32'(e));
    end
    rd_if.rd_ready = 1'b1;
    step();
    rd_if.rd_ready = 1'b0;
    e = exp_q.pop_front();
    chk("bp_idx2",  32'(rd_if.rd_idx), 2);
    chk("bp_d2",    32'(rd_if.rd_data), 32'(e));
    chk("bp_valid2", 32'(rd_if.rd_valid), 1);
    exp_q.delete();
    convert = 1'b0;
    ADC_reset = 1'b1;
    step();
    ADC_reset = 1'b0;
    chk("ovr_pulse", 32'(rd_if.rd_overrun), 1);
    chk("ovr_valid", 32'(rd_if.rd_valid), 0);
    chk("ovr_fin",   32'(ADC_finished), 0);
    step();
    chk("ovr_clear", 32'(rd_if.rd_overrun), 0);

    // Convert without arming after reset is ignored.
    reset = 1'b1;
    step();
    reset = 1'b0;
    convert = 1'b1;
    repeat (10) step();
    chk("noarm_dac", 32'(dac_code), 0);
    chk("noarm_fin", 32'(ADC_finished), 0);
    convert = 1'b0;

    // Abort mid-ramp at dac 4, then convert again while disarmed.
    ADC_reset = 1'b1;
    step();
    ADC_reset = 1'b0;
    convert = 1'b1;
    repeat (5) step();
    convert = 1'b0;
    step();
    chk("abort_fin",   32'(ADC_finished), 0);
    chk("abort_valid", 32'(rd_if.rd_valid), 0);
    convert = 1'b1;
    repeat (5) step();
    chk("abort_dac", 32'(dac_code), 4);
    chk("abort_fin2", 32'(ADC_finished), 0);
    convert = 1'b0;

    // Synchronous reset in the middle of a ramp and an exposure.
    set_pix(100, 150, 200, 250, 4'b1111);
    expose_cycles = 6'd10;
    expose_enable = 1'b1;
    ADC_reset = 1'b1;
    step();
    ADC_reset = 1'b0;
    convert = 1'b1;
    repeat (20) step();
    chk("pre_rst_dac", 32'(dac_code), 19);
    reset = 1'b1;
    step();
    chk("mid_rst_expfin", 32'(expose_finished), 0);
    chk("mid_rst_dac",    32'(dac_code), 0);
    chk("mid_rst_fin",    32'(ADC_finished), 0);
    chk("mid_rst_valid",  32'(rd_if.rd_valid), 0);
    chk("mid_rst_idx",    32'(rd_if.rd_idx), 0);
    chk("mid_rst_data",   32'(rd_if.rd_data), 0);
    chk("mid_rst_ovr",    32'(rd_if.rd_overrun), 0);
    reset = 1'b0;
    convert = 1'b0;
    expose_enable = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
